full_st0_tap_sched: RTL and testbench
=====================================

# full_st0_tap_sched

- Burst scheduler for the stage-0 tap memory write port.
- Shares one port between two requesters:
  - the input-stage tap loader (`load_*`);
  - the error-feedback writer (`err_*`), which is driven from the stage-0 error FIFO controller.
- Arbitrates at burst granularity and generates the tap address as phase and sub-address.
- Registers the memory write, and honours a memory hold coming from the read side.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: tap word width (carries `float_24_8`).
- `LEN_WIDTH`, default 3: burst length field width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `load_length` in `LEN_WIDTH`: burst length minus 1; sampled at grant.
- `mem_hold` in 1: memory busy; blocks new grants and stalls accepts.
- `load_vld` in 1 / `load_rdy` out 1 / `load_data` in `DATA_WIDTH`: loader stream.
- `err_vld` in 1 / `err_rdy` out 1 / `err_data` in `DATA_WIDTH`: error stream.
- `mem_wr_en` out 1: registered write strobe.
- `mem_addr` out `2+LEN_WIDTH`: `{phase[1:0], sub_addr}`.
- `mem_wr_data` out `DATA_WIDTH`: registered write data.
- `mem_wr_src` out 1: 0 = loader, 1 = error.
- `burst_done` out 1: pulse coincident with the last write of a burst.
- `load_phase` out 2, `err_phase` out 2: next phase per requester.
- `sched_busy` out 1: state is not IDLE.

## Operation

- FSM states: IDLE, LOAD, ERR. Reset state is IDLE.
- IDLE:
  - If `mem_hold` is high, stay in IDLE.
  - Otherwise, if any `vld` is high, grant one requester (see Configuration).
  - On grant, latch `load_length` into `len_q`, clear `sub_addr`, and go to LOAD or ERR.
  - No data is accepted in IDLE.
- LOAD / ERR:
  - Handshake: `load_rdy = (state==LOAD) & ~mem_hold`; `err_rdy = (state==ERR) & ~mem_hold`.
  - Both are combinational.
  - A transfer occurs when `vld & rdy`.
  - On each transfer, `sub_addr` increments.
  - On the transfer where `sub_addr == len_q`:
    - `sub_addr` returns to 0;
    - the owner's phase increments, wrapping 3 to 0;
    - `burst_done` is set for the write cycle;
    - the FSM returns to IDLE.
- `vld` low mid-burst: the owner keeps the grant, with no timeout. The other requester waits.
- `mem_hold` high mid-burst: `rdy` drops in the same cycle, and the counters and FSM freeze.
- `len_q == 0`: each burst is one word.
- A change of `load_length` mid-burst has no effect until the next grant.
- Write path: on a transfer, the next cycle shows
  - `mem_wr_en = 1`;
  - `mem_addr = {owner_phase, sub_addr}`, using the pre-increment values;
  - `mem_wr_data` = the accepted data;
  - `mem_wr_src` = the owner.
- Reset values: all outputs are 0, both phases are 0, `len_q` is 0.
- Reset mid-burst: the partial burst is abandoned, and the phases are not advanced beyond reset.

## Timing

- `vld` seen in IDLE → grant state next cycle → first `rdy` high in that cycle.
- Accept to `mem_wr_en`: 1 cycle.
- A burst of N = `len_q + 1` words takes N cycles plus one IDLE arbitration cycle. This gives one bubble between back-to-back bursts.
- `burst_done` and `load_phase`/`err_phase` update on the same edge: the edge after the last accept.

## Configuration

- `FULL_TAP_SCHED_RR_EN` defined:
  - round-robin arbitration;
  - when both are valid, the requester not served last wins;
  - the last winner resets to loader, so error wins the first tie.
- Undefined: fixed priority, error first; the loader is served only when `err_vld` is low in IDLE.

## Structure

- In the shared types package:
  - `float_24_8`;
  - the state encoding `TAP_SCHED_IDLE`/`LOAD`/`ERR`;
  - `TAP_PHASES = 4`.
- One sub-module, `full_tap_burst_counter`, instantiated once per requester. It provides:
  - `sub_addr` and the phase counter;
  - a `last` flag;
  - wrap handling.

## Test plan

- `load_length=3`, `load_vld` only, 4 words `0xA0`..`0xA3` → `mem_addr` 0,1,2,3; `burst_done` on addr 3; `load_phase` becomes 1.
- Both `vld` high in IDLE, `load_length=1`:
  - without the macro → ERR burst first, then LOAD;
  - with the macro → ERR, then LOAD, then ERR alternating.
- `mem_hold` pulsed for 2 cycles after word 1 of 4 → `rdy` low for exactly 2 cycles, no write; burst completes with contiguous addresses.
- 5 loader bursts with `load_length=0` → phases 0,1,2,3,0; `mem_addr` 0,8,16,24,0.
- `load_length` changed 3→1 mid-burst → the current burst still writes 4 words; the next burst writes 2.
- `reset` asserted after word 2 → all outputs 0 next cycle; a new burst starts at addr 0, phase 0.

Source files
------------

// File: rtl/full_st0_tap_sched_pkg.sv
// Shared types for the stage-0 tap memory write scheduler: tap word format,
// FSM state encoding, phase count and the phase wrap helper.
package full_st0_tap_sched_pkg;

  typedef struct packed {
    logic [23:0] mantissa;
    logic [7:0]  exponent;
  } float_24_8;

  typedef enum logic [1:0] {
    TAP_SCHED_IDLE = 2'd0,
    TAP_SCHED_LOAD = 2'd1,
    TAP_SCHED_ERR  = 2'd2
  } tap_sched_state_e;

  typedef enum logic {
    TAP_SRC_LOAD = 1'b0,
    TAP_SRC_ERR  = 1'b1
  } tap_src_e;

  localparam int TAP_PHASES  = 4;
  localparam int PHASE_WIDTH = $clog2(TAP_PHASES);

  function automatic logic [PHASE_WIDTH-1:0] next_phase(input logic [PHASE_WIDTH-1:0] phase);
    if (phase == PHASE_WIDTH'(TAP_PHASES - 1)) begin
      return {PHASE_WIDTH{1'b0}};
    end else begin
      return phase + PHASE_WIDTH'(1);
    end
  endfunction

endpackage

// File: rtl/full_st0_tap_sched_if.sv
// Valid/ready word stream feeding the tap scheduler (one instance per requester).
interface full_st0_tap_sched_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  vld;
  logic                  rdy;
  logic [DATA_WIDTH-1:0] data;

  modport master (output vld, output data, input rdy);
  modport slave  (input vld, input data, output rdy);
endinterface

// File: rtl/full_st0_tap_sched_burst_counter.sv
// Per-requester burst position: sub-address within the burst and tap phase,
// which advances once per completed burst and wraps after the last phase.
module full_tap_burst_counter
  import full_st0_tap_sched_pkg::*;
#(
  parameter int LEN_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   advance,
  input  logic [LEN_WIDTH-1:0]   len,
  output logic [LEN_WIDTH-1:0]   sub_addr,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   last
);

  logic [LEN_WIDTH-1:0]   sub_addr_r;
  logic [PHASE_WIDTH-1:0] phase_r;

  assign sub_addr = sub_addr_r;
  assign phase    = phase_r;
  assign last     = (sub_addr_r == len);

  // Sub-address and phase state; advance has priority over the grant-time clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      sub_addr_r <= {LEN_WIDTH{1'b0}};
      phase_r    <= {PHASE_WIDTH{1'b0}};
    end else if (advance) begin
      if (last) begin
        sub_addr_r <= {LEN_WIDTH{1'b0}};
        phase_r    <= next_phase(phase_r);
      end else begin
        sub_addr_r <= sub_addr_r + LEN_WIDTH'(1);
      end
    end else if (clear) begin
      sub_addr_r <= {LEN_WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/full_st0_tap_sched.sv
// Burst scheduler sharing the stage-0 tap memory write port between the tap
// loader and the error-feedback writer. Define FULL_TAP_SCHED_RR_EN for
// round-robin arbitration; otherwise the error stream has fixed priority.
module full_st0_tap_sched
  import full_st0_tap_sched_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LEN_WIDTH-1:0]   load_length,
  input  logic                   mem_hold,
  full_st0_tap_sched_if.slave    load_if,
  full_st0_tap_sched_if.slave    err_if,
  output logic                   mem_wr_en,
  output logic [LEN_WIDTH+1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wr_data,
  output logic                   mem_wr_src,
  output logic                   burst_done,
  output logic [1:0]             load_phase,
  output logic [1:0]             err_phase,
  output logic                   sched_busy
);

  tap_sched_state_e       state_r, state_s;
  logic [LEN_WIDTH-1:0]   len_q_r;
  logic                   grant_s, grant_err_s, pick_err_s;
  logic                   load_xfer_s, err_xfer_s;
  logic [LEN_WIDTH-1:0]   load_sub_s, err_sub_s;
  logic [PHASE_WIDTH-1:0] load_phase_s, err_phase_s;
  logic                   load_last_s, err_last_s;
  logic                   mem_wr_en_r, mem_wr_src_r, burst_done_r, sched_busy_r;
  logic [LEN_WIDTH+1:0]   mem_addr_r;
  logic [DATA_WIDTH-1:0]  mem_wr_data_r;

  assign load_if.rdy = (state_r == TAP_SCHED_LOAD) & ~mem_hold;
  assign err_if.rdy  = (state_r == TAP_SCHED_ERR) & ~mem_hold;
  assign load_xfer_s = load_if.vld & load_if.rdy;
  assign err_xfer_s  = err_if.vld & err_if.rdy;

`ifdef FULL_TAP_SCHED_RR_EN
  logic last_err_r;
  // On a tie the requester that did not win the previous grant goes next.
  assign pick_err_s = err_if.vld & (~load_if.vld | ~last_err_r);

  // Remembers the owner of the most recent grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_err_r <= 1'b0;
    end else if (grant_s) begin
      last_err_r <= grant_err_s;
    end
  end
`else
  assign pick_err_s = err_if.vld;
`endif

  // Next-state logic: grant one requester from IDLE, release after the last word.
  always_comb begin
    state_s     = state_r;
    grant_s     = 1'b0;
    grant_err_s = 1'b0;
    case (state_r)
      TAP_SCHED_IDLE: begin
        if (!mem_hold && (load_if.vld || err_if.vld)) begin
          grant_s     = 1'b1;
          grant_err_s = pick_err_s;
          state_s     = pick_err_s ? TAP_SCHED_ERR : TAP_SCHED_LOAD;
        end else begin
          state_s = TAP_SCHED_IDLE;
        end
      end
      TAP_SCHED_LOAD: begin
        if (load_xfer_s && load_last_s) begin
          state_s = TAP_SCHED_IDLE;
        end else begin
          state_s = TAP_SCHED_LOAD;
        end
      end
      TAP_SCHED_ERR: begin
        if (err_xfer_s && err_last_s) begin
          state_s = TAP_SCHED_IDLE;
        end else begin
          state_s = TAP_SCHED_ERR;
        end
      end
      default: state_s = TAP_SCHED_IDLE;
    endcase
  end

  // FSM state and the burst length captured at grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= TAP_SCHED_IDLE;
      len_q_r <= {LEN_WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      if (grant_s) begin
        len_q_r <= load_length;
      end
    end
  end

  full_tap_burst_counter #(.LEN_WIDTH(LEN_WIDTH)) u_load_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (grant_s & ~grant_err_s),
    .advance  (load_xfer_s),
    .len      (len_q_r),
    .sub_addr (load_sub_s),
    .phase    (load_phase_s),
    .last     (load_last_s)
  );

  full_tap_burst_counter #(.LEN_WIDTH(LEN_WIDTH)) u_err_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (grant_s & grant_err_s),
    .advance  (err_xfer_s),
    .len      (len_q_r),
    .sub_addr (err_sub_s),
    .phase    (err_phase_s),
    .last     (err_last_s)
  );

  // Registered write port; address uses the pre-increment phase and sub-address.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_wr_en_r   <= 1'b0;
      burst_done_r  <= 1'b0;
      mem_addr_r    <= {(LEN_WIDTH+2){1'b0}};
      mem_wr_data_r <= {DATA_WIDTH{1'b0}};
      mem_wr_src_r  <= TAP_SRC_LOAD;
      sched_busy_r  <= 1'b0;
    end else begin
      mem_wr_en_r  <= load_xfer_s | err_xfer_s;
      burst_done_r <= (load_xfer_s & load_last_s) | (err_xfer_s & err_last_s);
      sched_busy_r <= (state_s != TAP_SCHED_IDLE);
      if (err_xfer_s) begin
        mem_addr_r    <= {err_phase_s, err_sub_s};
        mem_wr_data_r <= err_if.data;
        mem_wr_src_r  <= TAP_SRC_ERR;
      end else if (load_xfer_s) begin
        mem_addr_r    <= {load_phase_s, load_sub_s};
        mem_wr_data_r <= load_if.data;
        mem_wr_src_r  <= TAP_SRC_LOAD;
      end
    end
  end

  assign mem_wr_en   = mem_wr_en_r;
  assign burst_done  = burst_done_r;
  assign mem_addr    = mem_addr_r;
  assign mem_wr_data = mem_wr_data_r;
  assign mem_wr_src  = mem_wr_src_r;
  assign sched_busy  = sched_busy_r;
  assign load_phase  = load_phase_s;
  assign err_phase   = err_phase_s;

endmodule

// File: tb/tb_full_st0_tap_sched.sv
// Self-checking bench for full_st0_tap_sched: a per-cycle behavioural model
// checked every cycle, plus hand-computed write logs for each directed scenario.
module tb_full_st0_tap_sched;

  localparam int DW = 32;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mem_hold = 1'b0;
  logic [LW-1:0] load_length = '0;
  logic          mem_wr_en, mem_wr_src, burst_done, sched_busy;
  logic [LW+1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic [1:0]    load_phase, err_phase;

  full_st0_tap_sched_if #(.DATA_WIDTH(DW)) load_if ();
  full_st0_tap_sched_if #(.DATA_WIDTH(DW)) err_if ();

  full_st0_tap_sched #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_length (load_length),
    .mem_hold    (mem_hold),
    .load_if     (load_if),
    .err_if      (err_if),
    .mem_wr_en   (mem_wr_en),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_wr_src  (mem_wr_src),
    .burst_done  (burst_done),
    .load_phase  (load_phase),
    .err_phase   (err_phase),
    .sched_busy  (sched_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit sim_done = 1'b0;

  // observed writes
  int w_addr[$];
  int w_data[$];
  int w_src[$];
  int w_done[$];

  // model: owner 0 none, 1 loader, 2 error; last winner 0 loader, 1 error
  int m_owner = 0, m_len = 0, m_idx = 0, m_last = 0;
  int m_phase[2] = '{0, 0};
  int e_wr_en = 0, e_addr = 0, e_data = 0, e_src = 0, e_done = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int  pick;
    int  k;
    bit  lx;
    bit  ex;
    if (reset) begin
      m_owner = 0; m_len = 0; m_idx = 0; m_last = 0;
      m_phase[0] = 0; m_phase[1] = 0;
      e_wr_en = 0; e_addr = 0; e_data = 0; e_src = 0; e_done = 0;
    end else begin
      lx = (m_owner == 1) && load_if.vld && !mem_hold;
      ex = (m_owner == 2) && err_if.vld && !mem_hold;
      e_wr_en = 0;
      e_done  = 0;
      if (m_owner == 0) begin
        if (!mem_hold && (load_if.vld || err_if.vld)) begin
`ifdef FULL_TAP_SCHED_RR_EN
          if (load_if.vld && err_if.vld) pick = (m_last == 1) ? 1 : 2;
          else pick = err_if.vld ? 2 : 1;
`else
          pick = err_if.vld ? 2 : 1;
`endif
          m_owner = pick;
          m_last  = pick - 1;
          m_len   = int'(load_length);
          m_idx   = 0;
        end
      end else if (lx || ex) begin
        k = m_owner - 1;
        e_wr_en = 1;
        e_addr  = m_phase[k] * (1 << LW) + m_idx;
        e_data  = lx ? int'(load_if.data) : int'(err_if.data);
        e_src   = k;
        if (m_idx == m_len) begin
          e_done     = 1;
          m_idx      = 0;
          m_phase[k] = (m_phase[k] + 1) % 4;
          m_owner    = 0;
        end else begin
          m_idx++;
        end
      end
    end
  endtask

  // compare process: outputs vs model each cycle, then advance the model
  initial begin
    forever begin
      @(negedge clk);
      if (sim_done) break;
      chk("load_rdy", int'(load_if.rdy), int'(m_owner == 1 && !mem_hold));
      chk("err_rdy", int'(err_if.rdy), int'(m_owner == 2 && !mem_hold));
      chk("wr_en", int'(mem_wr_en), e_wr_en);
      chk("burst_done", int'(burst_done), e_done);
      chk("load_phase", int'(load_phase), m_phase[0]);
      chk("err_phase", int'(err_phase), m_phase[1]);
      chk("sched_busy", int'(sched_busy), int'(m_owner != 0));
      if (e_wr_en != 0) begin
        chk("addr", int'(mem_addr), e_addr);
        chk("data", int'(mem_wr_data), e_data);
        chk("src", int'(mem_wr_src), e_src);
      end
      if (mem_wr_en) begin
        w_addr.push_back(int'(mem_addr));
        w_data.push_back(int'(mem_wr_data));
        w_src.push_back(int'(mem_wr_src));
        w_done.push_back(int'(burst_done));
      end
      model_step();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic xfer(input bit src, input int d);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    if (src) begin err_if.vld = 1'b1; err_if.data = d; end
    else begin load_if.vld = 1'b1; load_if.data = d; end
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = src ? err_if.rdy : load_if.rdy;
      @(posedge clk);
      #2;
      n++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic stream(input bit src, input int n, input int base);
    for (int i = 0; i < n; i++) xfer(src, base + i);
    if (src) err_if.vld = 1'b0;
    else load_if.vld = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  task automatic clear_log();
    w_addr.delete(); w_data.delete(); w_src.delete(); w_done.delete();
  endtask

  task automatic check_log(input string tag, input int n, input int ea[6],
                           input int ed[6], input int es[6], input int edn[6]);
    chk({tag, "_count"}, w_addr.size(), n);
    for (int i = 0; i < n && i < w_addr.size(); i++) begin
      chk({tag, "_addr"}, w_addr[i], ea[i]);
      chk({tag, "_data"}, w_data[i], ed[i]);
      chk({tag, "_src"}, w_src[i], es[i]);
      chk({tag, "_done"}, w_done[i], edn[i]);
    end
  endtask

  initial begin
    load_if.vld = 1'b0; load_if.data = '0;
    err_if.vld  = 1'b0; err_if.data  = '0;
    cycles(3);
    chk("rst_wr_en", int'(mem_wr_en), 0);
    chk("rst_addr", int'(mem_addr), 0);
    chk("rst_busy", int'(sched_busy), 0);
    chk("rst_phase", int'(load_phase) + int'(err_phase), 0);
    reset = 1'b0;
    cycles(1);

    // single loader burst of 4
    load_length = 3'd3;
    clear_log();
    stream(1'b0, 4, 'hA0);
    cycles(3);
    check_log("t1", 4, '{0, 1, 2, 3, 0, 0}, '{'hA0, 'hA1, 'hA2, 'hA3, 0, 0},
              '{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0});
    chk("t1_load_phase", int'(load_phase), 1);

    // both requesters valid from IDLE
    do_reset();
    load_length = 3'd1;
    clear_log();
    fork
      stream(1'b1, 4, 'hC0);
      stream(1'b0, 2, 'hB0);
    join
    cycles(3);
`ifdef FULL_TAP_SCHED_RR_EN
    check_log("t2", 6, '{0, 1, 0, 1, 8, 9}, '{'hC0, 'hC1, 'hB0, 'hB1, 'hC2, 'hC3},
              '{1, 1, 0, 0, 1, 1}, '{0, 1, 0, 1, 0, 1});
`else
    check_log("t2", 6, '{0, 1, 8, 9, 0, 1}, '{'hC0, 'hC1, 'hC2, 'hC3, 'hB0, 'hB1},
              '{1, 1, 1, 1, 0, 0}, '{0, 1, 0, 1, 0, 1});
`endif
    chk("t2_err_phase", int'(err_phase), 2);

    // memory hold for two cycles after the first word
    do_reset();
    load_length = 3'd3;
    clear_log();
    xfer(1'b0, 'hD0);
    mem_hold = 1'b1;
    load_if.data = 'hD1;
    repeat (2) begin
      @(negedge clk);
      chk("t3_hold_rdy", int'(load_if.rdy), 0);
      @(posedge clk);
      #2;
    end
    chk("t3_hold_nowrite", w_addr.size(), 1);
    mem_hold = 1'b0;
    @(negedge clk);
    chk("t3_release_rdy", int'(load_if.rdy), 1);
    @(posedge clk);
    #2;
    xfer(1'b0, 'hD2);
    xfer(1'b0, 'hD3);
    load_if.vld = 1'b0;
    cycles(3);
    check_log("t3", 4, '{0, 1, 2, 3, 0, 0}, '{'hD0, 'hD1, 'hD2, 'hD3, 0, 0},
              '{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0});

    // single-word bursts walk all phases and wrap
    do_reset();
    load_length = 3'd0;
    clear_log();
    stream(1'b0, 5, 'hE0);
    cycles(3);
    check_log("t4", 5, '{0, 8, 16, 24, 0, 0}, '{'hE0, 'hE1, 'hE2, 'hE3, 'hE4, 0},
              '{0, 0, 0, 0, 0, 0}, '{1, 1, 1, 1, 1, 0});
    chk("t4_load_phase", int'(load_phase), 1);

    // length change mid-burst applies only at the next grant
    do_reset();
    load_length = 3'd3;
    clear_log();
    xfer(1'b0, 'hF0);
    xfer(1'b0, 'hF1);
    load_length = 3'd1;
    stream(1'b0, 4, 'hF2);
    cycles(3);
    check_log("t5", 6, '{0, 1, 2, 3, 8, 9}, '{'hF0, 'hF1, 'hF2, 'hF3, 'hF4, 'hF5},
              '{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 1});

    // reset in the middle of a burst
    do_reset();
    load_length = 3'd3;
    xfer(1'b0, 'h10);
    xfer(1'b0, 'h11);
    reset = 1'b1;
    load_if.vld = 1'b0;
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("t6_wr_en", int'(mem_wr_en), 0);
    chk("t6_addr", int'(mem_addr), 0);
    chk("t6_data", int'(mem_wr_data), 0);
    chk("t6_src_done", int'(mem_wr_src) + int'(burst_done), 0);
    chk("t6_busy", int'(sched_busy), 0);
    chk("t6_phase", int'(load_phase), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    clear_log();
    stream(1'b0, 4, 'h20);
    cycles(3);
    check_log("t6", 4, '{0, 1, 2, 3, 0, 0}, '{'h20, 'h21, 'h22, 'h23, 0, 0},
              '{0, 0, 0, 0, 0, 0}, '{0, 0, 0, 1, 0, 0});
    chk("t6_load_phase", int'(load_phase), 1);

    sim_done = 1'b1;
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
